// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// Holds the FSM state encoding, the data/address width and timer defaults.
package mem_access_stage_pkg;

    localparam int DATA_W      = 16;
    localparam int TIMEOUT_DEF = 15;
    localparam int TMR_W_DEF   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Request/done bus between the memory-access stage and the data memory.
interface mem_access_stage_if;
    import mem_access_stage_pkg::*;

    // Handshake: dmem_en is a one-cycle request strobe; dmem_wr, dmem_addr and
    // dmem_wdata are meaningful only while dmem_en is high. The memory answers
    // with a one-cycle dmem_done pulse, carrying dmem_rdata for loads, after an
    // arbitrary number of cycles. Only one request is outstanding at a time.
    logic              dmem_en;
    logic              dmem_wr;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_done;

    modport master (
        output dmem_en, dmem_wr, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_done
    );

    modport slave (
        input  dmem_en, dmem_wr, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_done
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Clear/increment counter with a terminal-count flag, used to bound how long
// the stage waits for the data memory.
module mem_wait_timer #(
    parameter int TMR_W  = 8,
    parameter int TC_VAL = 14
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + TMR_W'(1);
        end
    end

    assign tc = (count == TMR_W'(TC_VAL));

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: issues loads/stores to a variable-latency memory, stalls
// upstream while waiting, aborts after TIMEOUT wait cycles. MEM_ALIGN_CHECK_EN rejects odd addresses.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TMR_W   = TMR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [DATA_W-1:0]   ALU_out,
    input  logic [DATA_W-1:0]   data_2_out,
    input  logic                mem_rd,
    input  logic                mem_wr,
    output logic                stall,
    mem_access_stage_if.master  dmem,
    output logic                valid_out,
    output logic [DATA_W-1:0]   wb_mem_data,
    output logic [DATA_W-1:0]   wb_alu,
    output logic                err,
    output state_t              dbg_state
);

    state_t            state;
    logic [DATA_W-1:0] cap_addr;
    logic              cap_wr;
    logic              is_mem;
    logic              is_illegal;
    logic              misaligned;
    logic              issue;
    logic              tmr_tc;

    assign is_mem     = mem_rd ^ mem_wr;
    assign is_illegal = mem_rd & mem_wr;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = ALU_out[0];
`else
    assign misaligned = 1'b0;
`endif

    // Request leaves in the same cycle the instruction arrives; reset gates it
    // so every output reads 0 while rst is high.
    assign issue = ~rst & (state == IDLE) & valid_in & is_mem & ~misaligned;
    assign stall = issue | ((state == WAIT) & ~dmem.dmem_done);

    assign dmem.dmem_en    = issue;
    assign dmem.dmem_wr    = issue & mem_wr;
    assign dmem.dmem_addr  = issue ? ALU_out : '0;
    assign dmem.dmem_wdata = issue ? data_2_out : '0;
    assign dbg_state       = state;

    mem_wait_timer #(
        .TMR_W  (TMR_W),
        .TC_VAL (TIMEOUT - 1)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (issue),
        .inc ((state == WAIT) & ~dmem.dmem_done),
        .tc  (tmr_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            valid_out   <= 1'b0;
            err         <= 1'b0;
            wb_mem_data <= '0;
            wb_alu      <= '0;
            cap_addr    <= '0;
            cap_wr      <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        if (is_illegal || (is_mem && misaligned)) begin
                            err <= 1'b1;
                        end else if (is_mem) begin
                            state    <= WAIT;
                            cap_addr <= ALU_out;
                            cap_wr   <= mem_wr;
                        end else begin
                            valid_out   <= 1'b1;
                            wb_alu      <= ALU_out;
                            wb_mem_data <= '0;
                        end
                    end
                end
                WAIT: begin
                    // A completion in the terminal cycle beats the timeout.
                    if (dmem.dmem_done) begin
                        state       <= IDLE;
                        valid_out   <= 1'b1;
                        wb_alu      <= cap_addr;
                        wb_mem_data <= cap_wr ? '0 : dmem.dmem_rdata;
                    end else if (tmr_tc) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: transaction-level expected queue plus
// a few literal pins. Build with MEM_ALIGN_CHECK_EN to exercise alignment rejection.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int TO    = 4;
    localparam int EXP_W = 65;   // {cycle[31:0], err, alu[15:0], mem[15:0]}

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [15:0] ALU_out;
    logic [15:0] data_2_out;
    logic        mem_rd;
    logic        mem_wr;
    logic        stall;
    logic        valid_out;
    logic [15:0] wb_mem_data;
    logic [15:0] wb_alu;
    logic        err;
    state_t      dbg_state;

    mem_access_stage_if dmem_bus ();

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [15:0] last_alu = '0;
    logic [15:0] last_mem = '0;

    mem_access_stage #(
        .TIMEOUT (TO),
        .TMR_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .ALU_out     (ALU_out),
        .data_2_out  (data_2_out),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .stall       (stall),
        .dmem        (dmem_bus),
        .valid_out   (valid_out),
        .wb_mem_data (wb_mem_data),
        .wb_alu      (wb_alu),
        .err         (err),
        .dbg_state   (dbg_state)
    );

    // Clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic is_err, input logic [15:0] alu, input logic [15:0] mem);
        exp_q.push_back({32'(cyc + 1), is_err, alu, mem});
    endtask

    // Compare process: every result the stage delivers must match the queue head
    // in cycle and content; between results the wb_* registers must hold.
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (!rst) begin
            if (exp_q.size() > 0 && int'(exp_q[0][64:33]) < cyc) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_fail++;
                $display("FAIL result_missing: nothing delivered by cycle %0d, required at cycle %0d",
                         cyc, e[64:33]);
            end
            if (valid_out || err) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: valid_out=%0b err=%0b at cycle %0d, required none",
                             valid_out, err, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_cycle", cyc, e[64:33]);
                    check("out_err", err, e[32]);
                    check("out_valid", valid_out, !e[32]);
                    if (!e[32]) begin
                        check("wb_alu", wb_alu, e[31:16]);
                        check("wb_mem_data", wb_mem_data, e[15:0]);
                        last_alu = e[31:16];
                        last_mem = e[15:0];
                    end else begin
                        check("hold_alu_err", wb_alu, last_alu);
                        check("hold_mem_err", wb_mem_data, last_mem);
                    end
                end
            end else begin
                check("hold_alu", wb_alu, last_alu);
                check("hold_mem", wb_mem_data, last_mem);
            end
        end
    end

    // Driver tasks: each starts one cycle after the previous one ended.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            valid_in = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
            dmem_bus.dmem_done = 1'b0;
        end
    endtask

    task automatic alu_op(input logic [15:0] addr);
        @(posedge clk); #1;
        valid_in = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0;
        ALU_out = addr; data_2_out = 16'($urandom_range(0, 65535));
        dmem_bus.dmem_done = 1'b0;
        @(negedge clk);
        check("alu_no_stall_no_req", {stall, dmem_bus.dmem_en}, 0);
        push_exp(1'b0, addr, 16'h0000);
    endtask

    task automatic illegal_op(input logic [15:0] addr);
        @(posedge clk); #1;
        valid_in = 1'b1; mem_rd = 1'b1; mem_wr = 1'b1;
        ALU_out = addr; data_2_out = 16'hDEAD;
        dmem_bus.dmem_done = 1'b0;
        @(negedge clk);
        check("illegal_no_stall_no_req", {stall, dmem_bus.dmem_en}, 0);
        push_exp(1'b1, 16'h0000, 16'h0000);
    endtask

    // done_at: WAIT cycle (1-based) in which memory answers; 0 = never.
    task automatic mem_op(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input int done_at, input logic [15:0] rdata);
        int stall_n;
        int en_n;
        int k;
        int exp_stall;
        bit finished;
        bit expect_req;
        expect_req = !(ALIGN_CHK && addr[0]);
        stall_n = 0;
        en_n    = 0;
        @(posedge clk); #1;
        valid_in = 1'b1; mem_rd = rd; mem_wr = wr;
        ALU_out = addr; data_2_out = wdata;
        dmem_bus.dmem_done = 1'b0;
        @(negedge clk);
        if (stall) stall_n++;
        if (dmem_bus.dmem_en) begin
            en_n++;
            check("req_addr", dmem_bus.dmem_addr, addr);
            check("req_wr", dmem_bus.dmem_wr, wr);
            check("req_wdata", dmem_bus.dmem_wdata, wdata);
        end
        if (!expect_req) begin
            push_exp(1'b1, 16'h0000, 16'h0000);
            exp_stall = 0;
        end else begin
            exp_stall = (done_at >= 1 && done_at <= TO) ? done_at : TO + 1;
            k = 0;
            finished = 1'b0;
            while (!finished) begin
                @(posedge clk); #1;
                k++;
                dmem_bus.dmem_done  = (k == done_at);
                dmem_bus.dmem_rdata = dmem_bus.dmem_done ? rdata : 16'($urandom_range(0, 65535));
                @(negedge clk);
                if (stall) stall_n++;
                if (dmem_bus.dmem_en) en_n++;
                if (k == done_at) begin
                    push_exp(1'b0, addr, rd ? rdata : 16'h0000);
                    finished = 1'b1;
                end else if (k == TO) begin
                    push_exp(1'b1, 16'h0000, 16'h0000);
                    finished = 1'b1;
                end
            end
        end
        check("stall_cycles", stall_n, exp_stall);
        check("req_count", en_n, expect_req ? 1 : 0);
    endtask

    task automatic pin_result(input logic [15:0] alu, input logic [15:0] mem);
        @(posedge clk); #1;
        valid_in = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        dmem_bus.dmem_done = 1'b0;
        @(negedge clk);
        check("pin_valid", valid_out, 1);
        check("pin_alu", wb_alu, alu);
        check("pin_mem", wb_mem_data, mem);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    endtask

    initial begin
        #100000;
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: time limit reached before end of test");
        summary();
        $finish;
    end

    initial begin
        int sel;
        int d;
        logic [15:0] a;
        rst = 1'b1; valid_in = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        ALU_out = '0; data_2_out = '0;
        dmem_bus.dmem_done = 1'b0; dmem_bus.dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_err", err, 0);
        check("rst_wb_alu", wb_alu, 0);
        check("rst_wb_mem", wb_mem_data, 0);
        check("rst_stall_en", {stall, dmem_bus.dmem_en}, 0);
        check("rst_state", dbg_state, IDLE);
        @(posedge clk); #1;
        rst = 1'b0;

        // ALU pass-through, latency 1, back to back
        alu_op(16'h1234);
        pin_result(16'h1234, 16'h0000);
        alu_op(16'hFFFF);
        alu_op(16'h0000);
        alu_op(16'h5A5A);
        idle(1);

        // Load, memory answers in third WAIT cycle
        mem_op(1'b1, 1'b0, 16'h0040, 16'h3333, 3, 16'hBEEF);
        pin_result(16'h0040, 16'hBEEF);

        // Store, immediate done
        mem_op(1'b0, 1'b1, 16'h0010, 16'hA5A5, 1, 16'h1111);
        pin_result(16'h0010, 16'h0000);

        // Back to back: load, store answered in the timeout cycle, ALU op
        mem_op(1'b1, 1'b0, 16'h0200, 16'h0000, 2, 16'hC0DE);
        mem_op(1'b0, 1'b1, 16'h0202, 16'h7777, TO, 16'h2222);
        alu_op(16'h0ABC);
        idle(1);

        // Timeout, then a late done in IDLE must be ignored
        mem_op(1'b1, 1'b0, 16'h0100, 16'h0000, 0, 16'h0000);
        @(posedge clk); #1;
        valid_in = 1'b0; mem_rd = 1'b0;
        dmem_bus.dmem_done = 1'b1; dmem_bus.dmem_rdata = 16'h9999;
        @(negedge clk);
        check("timeout_err_pin", {err, valid_out}, 2'b10);
        idle(2);

        // Illegal rd+wr
        illegal_op(16'h0300);
        idle(2);

        // Odd address: rejected with the check enabled, passed through otherwise
        mem_op(1'b1, 1'b0, 16'h0041, 16'h0000, 2, 16'h7E57);
        idle(1);

        for (int i = 0; i < 10; i++) begin
            sel = $urandom_range(0, 3);
            d   = $urandom_range(0, TO + 1);
            a   = 16'($urandom_range(0, 65535));
            case (sel)
                0: alu_op(a);
                1: mem_op(1'b1, 1'b0, a, 16'h0000, d, 16'($urandom_range(0, 65535)));
                2: mem_op(1'b0, 1'b1, a, 16'($urandom_range(0, 65535)), d, 16'h0F0F);
                default: illegal_op(a);
            endcase
        end
        alu_op(16'h4321);
        idle(2);

        // Asynchronous reset in the middle of WAIT
        @(posedge clk); #1;
        valid_in = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0;
        ALU_out = 16'h0080; dmem_bus.dmem_done = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        last_alu = '0;
        last_mem = '0;
        #1;
        check("midrst_stall_en", {stall, dmem_bus.dmem_en}, 0);
        check("midrst_valid_err", {valid_out, err}, 0);
        check("midrst_wb_alu", wb_alu, 0);
        check("midrst_wb_mem", wb_mem_data, 0);
        check("midrst_state", dbg_state, IDLE);
        @(posedge clk); #1;
        valid_in = 1'b0; mem_rd = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        dmem_bus.dmem_done = 1'b1; dmem_bus.dmem_rdata = 16'h5555;
        @(negedge clk);
        check("post_rst_done_stall", stall, 0);
        idle(1);
        @(negedge clk);
        check("post_rst_no_valid", valid_out, 0);
        alu_op(16'h00F0);
        idle(3);

        check("queue_empty", exp_q.size(), 0);
        summary();
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Stage directly downstream of execute. Consumes ALU_out (address or result) and data_2_out (store data).
- Performs loads and stores against a variable-latency data memory using a request/done handshake.
- Stalls upstream while an access is outstanding.
- Delivers registered results to writeback.

Parameters:
- DATA_W, 16, data and address width.
- TIMEOUT, 15, max cycles in WAIT before an access is aborted with error; range 1..255.
- TMR_W, 8, timeout counter width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  execute result valid this cycle
- ALU_out  in  16  ALU result; memory address for loads and stores
- data_2_out  in  16  store data
- mem_rd  in  1  instruction is a load
- mem_wr  in  1  instruction is a store
- stall  out  1  combinational; upstream holds its inputs while high
- dmem_en  out  1  one-cycle request strobe to data memory
- dmem_wr  out  1  write qualifier, valid with dmem_en
- dmem_addr  out  16  request address, valid with dmem_en
- dmem_wdata  out  16  request write data, valid with dmem_en
- dmem_rdata  in  16  read data, valid with dmem_done
- dmem_done  in  1  access complete, one-cycle pulse
- valid_out  out  1  registered; result valid for writeback
- wb_mem_data  out  16  registered load data (0 for non-loads)
- wb_alu  out  16  registered ALU_out pass-through
- err  out  1  registered one-cycle pulse on illegal or aborted access

Behaviour:
- Reset: all outputs 0, state IDLE, timer 0. Reset is async and can occur mid-WAIT.
  - Any dmem_done arriving after reset in IDLE is ignored.
- States: IDLE, WAIT.
- IDLE, valid_in=0: valid_out=0 next cycle.
- IDLE, valid_in=1, mem_rd=mem_wr=0 (ALU op):
  - Next cycle: valid_out=1, wb_alu=ALU_out, wb_mem_data=0.
  - No stall; latency 1.
- IDLE, valid_in=1, exactly one of mem_rd/mem_wr:
  - Same cycle: dmem_en=1, dmem_wr=mem_wr, dmem_addr=ALU_out, dmem_wdata=data_2_out, stall=1.
  - Capture address and op internally; go to WAIT; timer cleared.
- IDLE, valid_in=1, mem_rd=mem_wr=1:
  - No request; next cycle err=1, valid_out=0.
- WAIT, dmem_done=0:
  - stall=1, dmem_en=0, timer increments.
  - When timer reaches TIMEOUT-1 in that cycle: go IDLE, next cycle err=1, valid_out=0, stall released in that cycle.
- WAIT, dmem_done=1:
  - stall=0 that cycle; go IDLE.
  - Next cycle: valid_out=1, wb_alu=captured address, wb_mem_data=dmem_rdata for loads or 0 for stores.
  - Minimum load/store latency is 2 cycles (done in the first WAIT cycle).
- dmem_done in the same cycle as timeout: done wins; no err.
- Upstream presents the next instruction while stall=0. A new request can issue in the cycle after done is taken.
- Outputs not updated on a given cycle revert to: valid_out=0, err=0. wb_* hold their last value.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: a load or store with ALU_out[0]=1 issues no request and gives err=1 next cycle, valid_out=0, no stall.
- Undefined: no alignment check; the address is passed unchanged and memory handles byte-lane behaviour.

Decomposition:
- Shared package holds: state encoding (IDLE=1'b0, WAIT=1'b1), DATA_W, the default TIMEOUT constant.
- One sub-module is natural: mem_wait_timer, a clear/increment/terminal-count counter of width TMR_W.

Test Plan:
- ALU op: valid_in=1, rd=wr=0, ALU_out=16'h1234 -> next cycle valid_out=1, wb_alu=16'h1234, wb_mem_data=0, stall never high.
- Load, 3-cycle memory: rd=1, ALU_out=16'h0040; dmem_done on WAIT cycle 3 with rdata=16'hBEEF -> dmem_en pulses once with addr 16'h0040; stall high 3 cycles; then valid_out=1, wb_mem_data=16'hBEEF.
- Store, immediate done: wr=1, addr 16'h0010, data 16'hA5A5 -> dmem_wr=1, dmem_wdata=16'hA5A5; valid_out=1 two cycles after issue; wb_mem_data=0.
- Timeout: load with no dmem_done, TIMEOUT=4 -> stall high 5 cycles (issue + 4 WAIT); err=1 for one cycle; valid_out stays 0; a late dmem_done is ignored.
- Illegal and reset cases:
  - rd=wr=1 -> err=1, no dmem_en.
  - Separately, rst asserted mid-WAIT -> all outputs 0 immediately; a following dmem_done produces no valid_out.
- With MEM_ALIGN_CHECK_EN defined: load at 16'h0041 -> err=1, no dmem_en. Without it: request issues with dmem_addr=16'h0041.
